// File: rtl/fifo_flow_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_flow_ctrl
//   Per-channel synchronous FIFO for the switching datapath. Provides an
//   occupancy count, programmable almost-full / almost-empty flags, a
//   hysteresis-based pause (backpressure) output and a sticky error flag
//   for overflow / underflow. All status outputs are registered and derived
//   from the next-state count, so they are coherent with data_count.
//
// Parameters
//   DATA_SIZE : data word width
//   ADDR_SIZE : address width, depth = 2**ADDR_SIZE
//
// Ports
//   clk              : clock, rising edge
//   reset_L          : asynchronous active-low reset
//   write            : push request, buff_in sampled on the same edge
//   read             : pop request
//   buff_in          : push data
//   umb_almost_full  : almost-full / pause-set threshold
//   umb_almost_empty : almost-empty / pause-clear threshold
//   buffer_out       : registered pop data (holds when no pop)
//   valid_out        : one-cycle strobe, buffer_out carries a new word
//   data_count       : occupancy 0..DEPTH
//   fifo_full        : data_count == DEPTH
//   fifo_empty       : data_count == 0
//   almost_full      : data_count >= umb_almost_full
//   almost_empty     : data_count <= umb_almost_empty
//   fifo_pause       : backpressure to upstream, with hysteresis
//   fifo_error       : sticky overflow/underflow, cleared only by reset
// ---------------------------------------------------------------------------
module fifo_flow_ctrl #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] buff_in,
    input  logic [ADDR_SIZE:0]   umb_almost_full,
    input  logic [ADDR_SIZE:0]   umb_almost_empty,
    output logic [DATA_SIZE-1:0] buffer_out,
    output logic                 valid_out,
    output logic [ADDR_SIZE:0]   data_count,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic                 fifo_error
);

    localparam int                 DEPTH     = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE + 1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic [DATA_SIZE-1:0] buffer_out_q;
    logic                 valid_q;
    logic                 full_q, empty_q, afull_q, aempty_q;
    logic                 pause_q, pause_d;
    logic                 error_q, error_d;
    logic                 wr_acc, rd_acc;

    // Request qualification and next-state count / pause / error
    always_comb begin
        // A full FIFO still accepts a write when a pop frees a slot in the
        // same cycle; an empty FIFO never pops, so no write-to-read bypass.
        wr_acc = write && (!full_q || read);
        rd_acc = read && !empty_q;

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end

        // Set has priority so overlapping thresholds resolve to paused.
        pause_d = pause_q;
        if (count_d >= umb_almost_full) begin
            pause_d = 1'b1;
        end else if (count_d <= umb_almost_empty) begin
            pause_d = 1'b0;
        end

        error_d = error_q
                | (write && full_q && !read)
                | (read && empty_q);
    end

    // Storage array: data only, not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= buff_in;
        end
    end

    // Control, status and output register stage
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            buffer_out_q <= '0;
            valid_q      <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
            pause_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q     <= rd_ptr_q + 1'b1;
                buffer_out_q <= mem[rd_ptr_q];
            end
            valid_q  <= rd_acc;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_CNT);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= umb_almost_full);
            aempty_q <= (count_d <= umb_almost_empty);
            pause_q  <= pause_d;
            error_q  <= error_d;
        end
    end

    assign buffer_out   = buffer_out_q;
    assign valid_out    = valid_q;
    assign data_count   = count_q;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign fifo_pause   = pause_q;
    assign fifo_error   = error_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
module tb_fifo_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       write, read;
    logic [5:0] buff_in;
    logic [3:0] umb_almost_full, umb_almost_empty;
    logic [5:0] buffer_out;
    logic       valid_out;
    logic [3:0] data_count;
    logic       fifo_full, fifo_empty, almost_full, almost_empty;
    logic       fifo_pause, fifo_error;

    fifo_flow_ctrl #(.DATA_SIZE(6), .ADDR_SIZE(3)) dut (
        .clk(clk), .reset_L(reset_L), .write(write), .read(read),
        .buff_in(buff_in), .umb_almost_full(umb_almost_full),
        .umb_almost_empty(umb_almost_empty), .buffer_out(buffer_out),
        .valid_out(valid_out), .data_count(data_count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_pause(fifo_pause), .fifo_error(fifo_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [5:0] din;
        logic [3:0] ecount;
        logic       epause;
        logic       eerr;
    } vec_t;

    vec_t tbl[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FIFO contents, pending expected pops, hysteresis, error
    logic [5:0] mdl[$];
    logic [5:0] exp_q[$];
    logic       m_pause, m_err, m_valid;
    logic [5:0] last_dout;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl.delete();
        exp_q.delete();
        m_pause   = 1'b0;
        m_err     = 1'b0;
        m_valid   = 1'b0;
        last_dout = 6'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, int'(data_count), 0);
        check({tag, "_empty"}, int'(fifo_empty), 1);
        check({tag, "_full"},  int'(fifo_full), 0);
        check({tag, "_af"},    int'(almost_full), 0);
        check({tag, "_ae"},    int'(almost_empty), 1);
        check({tag, "_pause"}, int'(fifo_pause), 0);
        check({tag, "_err"},   int'(fifo_error), 0);
        check({tag, "_valid"}, int'(valid_out), 0);
        check({tag, "_dout"},  int'(buffer_out), 0);
    endtask

    // One clock: drive on negedge, update model, sample #1 after posedge
    task automatic step(input logic wr, input logic rd, input logic [5:0] din);
        int sz;
        int nc;
        logic wacc, racc;
        @(negedge clk);
        write   = wr;
        read    = rd;
        buff_in = din;
        sz   = mdl.size();
        wacc = wr && (sz < 8 || rd);
        racc = rd && (sz > 0);
        if ((wr && sz == 8 && !rd) || (rd && sz == 0)) m_err = 1'b1;
        if (racc) exp_q.push_back(mdl.pop_front());
        if (wacc) mdl.push_back(din);
        m_valid = racc;
        nc = mdl.size();
        if (nc >= int'(umb_almost_full)) m_pause = 1'b1;
        else if (nc <= int'(umb_almost_empty)) m_pause = 1'b0;
        @(posedge clk);
        #1;
        check("count", int'(data_count), nc);
        check("full",  int'(fifo_full), int'(nc == 8));
        check("empty", int'(fifo_empty), int'(nc == 0));
        check("almost_full",  int'(almost_full),  int'(nc >= int'(umb_almost_full)));
        check("almost_empty", int'(almost_empty), int'(nc <= int'(umb_almost_empty)));
        check("pause", int'(fifo_pause), int'(m_pause));
        check("error", int'(fifo_error), int'(m_err));
        check("valid", int'(valid_out), int'(m_valid));
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", int'(buffer_out), -1);
            end else begin
                last_dout = exp_q.pop_front();
                check("dout", int'(buffer_out), int'(last_dout));
            end
        end else begin
            check("dout_hold", int'(buffer_out), int'(last_dout));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_L = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        #1 model_reset();
        check_reset_outputs("reset");
        #1 reset_L = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L = 1'b0;
        write = 1'b0; read = 1'b0; buff_in = 6'h00;
        umb_almost_full = 4'd6; umb_almost_empty = 4'd3;
        model_reset();

        // wr, rd, din, expected count, pause, error
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b1, 1'b0, 6'(i + 3), 4'(i + 1), (i >= 5), 1'b0});
        tbl.push_back('{1'b1, 1'b0, 6'h0B, 4'd8, 1'b1, 1'b1});  // overflow
        tbl.push_back('{1'b0, 1'b0, 6'h00, 4'd8, 1'b1, 1'b1});  // error sticky
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd7, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd6, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd5, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd4, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd3, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd2, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 6'h00, 4'd0, 1'b0, 1'b1});  // underflow

        repeat (2) @(posedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        #2 reset_L = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            check($sformatf("tbl%0d_count", i), int'(data_count), int'(tbl[i].ecount));
            check($sformatf("tbl%0d_pause", i), int'(fifo_pause), int'(tbl[i].epause));
            check($sformatf("tbl%0d_err", i),   int'(fifo_error), int'(tbl[i].eerr));
        end
        check("underflow_valid", int'(valid_out), 0);
        check("underflow_hold",  int'(buffer_out), 'h0A);

        // Wrap-around with an out-of-range almost-full threshold
        do_reset();
        umb_almost_full = 4'd9; umb_almost_empty = 4'd0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(6'h20 + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 6'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'(6'h30 + i));
        check("wrap_full", int'(fifo_full), 1);
        check("wrap_af_never", int'(almost_full), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00);
        check("wrap_last", int'(buffer_out), 'h37);
        check("wrap_noerr", int'(fifo_error), 0);

        // Simultaneous read+write at full, then at empty
        umb_almost_full = 4'd6; umb_almost_empty = 4'd3;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'(6'h10 + i));
        step(1'b1, 1'b1, 6'h3F);
        check("rw_full_count", int'(data_count), 8);
        check("rw_full_err", int'(fifo_error), 0);
        check("rw_full_dout", int'(buffer_out), 'h10);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00);
        check("drained_last", int'(buffer_out), 'h3F);
        step(1'b1, 1'b1, 6'h2A);
        check("rw_empty_count", int'(data_count), 1);
        check("rw_empty_err", int'(fifo_error), 1);
        check("rw_empty_valid", int'(valid_out), 0);
        step(1'b0, 1'b1, 6'h00);
        check("rw_empty_word", int'(buffer_out), 'h2A);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom));

        // Reset mid-stream at count 4, then a fresh transfer
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'(6'h01 + i));
        check("pre_reset_count", int'(data_count), 4);
        do_reset();
        step(1'b1, 1'b0, 6'h15);
        step(1'b0, 1'b1, 6'h00);
        check("post_reset_dout", int'(buffer_out), 'h15);
        check("post_reset_valid", int'(valid_out), 1);
        step(1'b0, 1'b0, 6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
